// File: rtl/stopwatch_ctrl_pkg.sv
// Shared definitions for the stopwatch run/pause/clear sequencer:
// state codes, counter width and the divider derivation helpers.
package stopwatch_ctrl_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_PAUSE = 2'd2,
      S_DONE  = 2'd3
   } sw_state_t;

   localparam int unsigned CNT_W = 32;

   // Clock cycles between count strobes while running.
   function automatic logic [CNT_W-1:0] calc_div(input int unsigned clkfreq,
                                                 input int unsigned tickfreq);
      logic [63:0] t;
      t = 64'(clkfreq) / 64'(tickfreq);
      return t[CNT_W-1:0];
   endfunction

   // Clock cycles the start button must be held to force a clear.
   function automatic logic [CNT_W-1:0] calc_lp(input int unsigned clkfreq,
                                                input int unsigned longpress_ms);
      logic [63:0] t;
      t = (64'(clkfreq) / 64'd1000) * 64'(longpress_ms);
      return t[CNT_W-1:0];
   endfunction

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Button/counter-side signal bundle of the stopwatch sequencer.
// The master side drives button levels and the limit flag; the slave is the sequencer.
interface stopwatch_ctrl_if;
   import stopwatch_ctrl_pkg::*;

   logic      start_i;
   logic      clear_i;
   logic      limit_i;
   logic      count_en_o;
   logic      clear_o;
   logic      running_o;
   sw_state_t state_o;

   modport master (
      output start_i, clear_i, limit_i,
      input  count_en_o, clear_o, running_o, state_o
   );

   modport slave (
      input  start_i, clear_i, limit_i,
      output count_en_o, clear_o, running_o, state_o
   );

endinterface

// File: rtl/stopwatch_ctrl_tick_prescaler.sv
// Free-running divider for the stopwatch count strobe: counts while run=1, holds
// while run=0, and zero=1 synchronously restarts it. tick flags the wrapping cycle.
module tick_prescaler
   import stopwatch_ctrl_pkg::*;
#(
   parameter logic [CNT_W-1:0] DIV = 10
) (
   input  logic clk,
   input  logic rst,
   input  logic run,
   input  logic zero,
   output logic tick
);

   logic [CNT_W-1:0] cnt;
   logic             wrap;

   assign wrap = (cnt == DIV - 1);
   // Combinational so the owner can register the strobe alongside its FSM outputs.
   assign tick = run & wrap;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (zero) begin
         cnt <= '0;
      end else if (run) begin
         cnt <= wrap ? '0 : cnt + 1'b1;
      end
   end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Run/pause/clear sequencer for the 4-digit stopwatch: turns debounced button levels
// into a count-enable strobe for the BCD digit counter and a clear strobe.
module stopwatch_ctrl
   import stopwatch_ctrl_pkg::*;
#(
   parameter int unsigned c_clkfreq      = 100_000_000,
   parameter int unsigned c_tickfreq     = 100,
   parameter int unsigned c_longpress_ms = 1000
) (
   input  logic              clk,
   input  logic              rst,
   stopwatch_ctrl_if.slave   bus
);

   localparam logic [CNT_W-1:0] C_DIV = calc_div(c_clkfreq, c_tickfreq);
   localparam logic [CNT_W-1:0] C_LP  = calc_lp(c_clkfreq, c_longpress_ms);

   sw_state_t        state;
   logic             start_q, clear_q;
   logic [CNT_W-1:0] lp_cnt;
   logic             lp_fired;
   logic             count_en, clear_pulse, running;
   logic             start_rise, clear_rise, long_evt;
   logic             pre_run, pre_zero, tick;

   assign start_rise = bus.start_i & ~start_q;
   assign clear_rise = bus.clear_i & ~clear_q;
   // Fires once per hold; lp_fired blocks repeats while the counter sits saturated.
   assign long_evt   = bus.start_i & ~lp_fired & (lp_cnt == C_LP - 1);

   // Prescaler advances only on cycles that stay in S_RUN.
   assign pre_run  = (state == S_RUN) & ~long_evt & ~bus.limit_i & ~start_rise;
   assign pre_zero = long_evt
                   | (state == S_IDLE)
                   | ((state == S_PAUSE) & clear_rise & ~start_rise)
                   | ((state == S_DONE) & clear_rise);

   tick_prescaler #(.DIV(C_DIV)) u_prescaler (
      .clk  (clk),
      .rst  (rst),
      .run  (pre_run),
      .zero (pre_zero),
      .tick (tick)
   );

   // Edge detectors start high so a button held through reset release is not a press.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         start_q  <= 1'b1;
         clear_q  <= 1'b1;
         lp_cnt   <= '0;
         lp_fired <= 1'b0;
      end else begin
         start_q <= bus.start_i;
         clear_q <= bus.clear_i;
         if (!bus.start_i) begin
            lp_cnt   <= '0;
            lp_fired <= 1'b0;
         end else begin
            if (lp_cnt != C_LP - 1) lp_cnt <= lp_cnt + 1'b1;
            if (long_evt)           lp_fired <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_IDLE;
         count_en    <= 1'b0;
         clear_pulse <= 1'b0;
         running     <= 1'b0;
      end else begin
         count_en    <= tick;
         clear_pulse <= 1'b0;
         if (long_evt) begin
            state       <= S_IDLE;
            clear_pulse <= 1'b1;
            running     <= 1'b0;
         end else begin
            case (state)
               S_IDLE: begin
                  if (start_rise) begin
                     state   <= S_RUN;
                     running <= 1'b1;
                  end else if (clear_rise) begin
                     clear_pulse <= 1'b1;
                  end
               end
               S_RUN: begin
                  if (bus.limit_i) begin
                     state   <= S_DONE;
                     running <= 1'b0;
                  end else if (start_rise) begin
                     state   <= S_PAUSE;
                     running <= 1'b0;
                  end
               end
               S_PAUSE: begin
                  if (start_rise) begin
                     state   <= S_RUN;
                     running <= 1'b1;
                  end else if (clear_rise) begin
                     state       <= S_IDLE;
                     clear_pulse <= 1'b1;
                  end
               end
               S_DONE: begin
                  if (clear_rise) begin
                     state       <= S_IDLE;
                     clear_pulse <= 1'b1;
                  end
               end
               default: begin
                  state   <= S_IDLE;
                  running <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.count_en_o = count_en;
   assign bus.clear_o    = clear_pulse;
   assign bus.running_o  = running;
   assign bus.state_o    = state;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl with C_DIV=10 and C_LP=20:
// a vector table with queued expectations plus hand-written timing and reset sequences.
`timescale 1ns/1ps
module tb_stopwatch_ctrl;
   import stopwatch_ctrl_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;

   stopwatch_ctrl_if bus();

   stopwatch_ctrl #(
      .c_clkfreq      (1000),
      .c_tickfreq     (100),
      .c_longpress_ms (20)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       st;
      logic       cl;
      logic       lim;
      int         n;
      logic [1:0] e_state;
      logic       e_run;
      int         e_str;
      int         e_clr;
   } vec_t;

   typedef struct {
      logic [1:0] state;
      logic       run;
      int         str;
      int         clr;
   } exp_t;

   vec_t vecs[$];
   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   task automatic add(input logic st, input logic cl, input logic lim, input int n,
                      input logic [1:0] s, input logic r, input int str, input int clr);
      vec_t v;
      v.st = st; v.cl = cl; v.lim = lim; v.n = n;
      v.e_state = s; v.e_run = r; v.e_str = str; v.e_clr = clr;
      vecs.push_back(v);
   endtask

   task automatic cyc(input logic st, input logic cl, input logic lim, input int n);
      bus.start_i = st;
      bus.clear_i = cl;
      bus.limit_i = lim;
      repeat (n) @(negedge clk);
   endtask

   // Negedges until count_en_o is seen; limit+1 means it never came.
   task automatic wait_strobe(input int limit, output int k);
      k = 0;
      while (k < limit) begin
         @(negedge clk);
         k++;
         if (bus.count_en_o === 1'b1) return;
      end
      k = limit + 1;
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int   str;
      int   clr;
      exp_t e;
      exp_t got;
      str = 0;
      clr = 0;
      e.state = v.e_state; e.run = v.e_run; e.str = v.e_str; e.clr = v.e_clr;
      bus.start_i = v.st;
      bus.clear_i = v.cl;
      bus.limit_i = v.lim;
      exp_q.push_back(e);
      repeat (v.n) begin
         @(negedge clk);
         if (bus.count_en_o === 1'b1) str++;
         if (bus.clear_o === 1'b1)    clr++;
      end
      got = exp_q.pop_front();
      check($sformatf("vec%0d state", idx),   32'(bus.state_o),   32'(got.state));
      check($sformatf("vec%0d running", idx), 32'(bus.running_o), 32'(got.run));
      check($sformatf("vec%0d strobes", idx), 32'(str),           32'(got.str));
      check($sformatf("vec%0d clears", idx),  32'(clr),           32'(got.clr));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      int clr;

      //   st cl lim  n  state run str clr
      add(0, 0, 0,  2,  0, 0, 0, 0);
      add(1, 0, 0,  3,  1, 1, 0, 0);   // start press -> run
      add(0, 0, 0, 25,  1, 1, 2, 0);   // strobes 10 and 20 edges after entry
      add(1, 0, 0,  1,  2, 0, 0, 0);   // pause
      add(0, 0, 0, 15,  2, 0, 0, 0);
      add(1, 0, 0,  1,  1, 1, 0, 0);   // resume with prescaler at 7
      add(0, 0, 0,  3,  1, 1, 1, 0);
      add(1, 0, 0,  1,  2, 0, 0, 0);
      add(0, 0, 0,  2,  2, 0, 0, 0);
      add(0, 1, 0,  1,  0, 0, 0, 1);   // clear from pause
      add(0, 0, 0, 20,  0, 0, 0, 0);
      add(1, 0, 0,  1,  1, 1, 0, 0);
      add(0, 0, 0,  9,  1, 1, 0, 0);   // prescaler now at 9
      add(0, 0, 1,  1,  3, 0, 0, 0);   // limit suppresses the due strobe
      add(0, 0, 1,  3,  3, 0, 0, 0);
      add(1, 0, 1,  1,  3, 0, 0, 0);   // start ignored in done
      add(0, 0, 0, 12,  3, 0, 0, 0);
      add(0, 1, 0,  1,  0, 0, 0, 1);   // clear from done
      add(0, 0, 0,  2,  0, 0, 0, 0);
      add(0, 1, 0,  1,  0, 0, 0, 1);   // clear in idle
      add(0, 0, 0,  2,  0, 0, 0, 0);
      add(1, 0, 0,  1,  1, 1, 0, 0);
      add(0, 0, 0,  2,  1, 1, 0, 0);
      add(0, 1, 0,  1,  1, 1, 0, 0);   // clear ignored in run
      add(0, 0, 0,  7,  1, 1, 1, 0);
      add(1, 0, 0,  1,  2, 0, 0, 0);
      add(0, 0, 0,  2,  2, 0, 0, 0);
      add(1, 1, 0,  1,  1, 1, 0, 0);   // start beats clear in pause
      add(0, 0, 0,  2,  1, 1, 0, 0);
      add(1, 0, 0,  1,  2, 0, 0, 0);
      add(0, 0, 0,  1,  2, 0, 0, 0);
      add(0, 1, 0,  1,  0, 0, 0, 1);
      add(0, 0, 0,  2,  0, 0, 0, 0);
      add(1, 0, 0, 25,  0, 0, 1, 1);   // long press: run, one strobe, forced clear
      add(0, 0, 0,  3,  0, 0, 0, 0);   // no second clear on release

      bus.start_i = 1'b0;
      bus.clear_i = 1'b0;
      bus.limit_i = 1'b0;
      repeat (2) @(negedge clk);
      check("reset state",    32'(bus.state_o),    32'(0));
      check("reset running",  32'(bus.running_o),  32'(0));
      check("reset count_en", 32'(bus.count_en_o), 32'(0));
      check("reset clear",    32'(bus.clear_o),    32'(0));
      rst = 1'b0;

      for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

      // Resume latency: prescaler parked at 5 -> strobe 5 cycles after resume.
      cyc(1, 0, 0, 1);
      cyc(0, 0, 0, 25);
      cyc(1, 0, 0, 1);
      cyc(0, 0, 0, 4);
      check("h1 paused", 32'(bus.state_o), 32'(2));
      cyc(1, 0, 0, 1);
      bus.start_i = 1'b0;
      wait_strobe(30, k);
      check("h1 resume to strobe", 32'(k), 32'(5));

      // First strobe latency, width and period from a fresh start.
      cyc(1, 0, 0, 1);
      cyc(0, 0, 0, 1);
      cyc(0, 1, 0, 1);
      cyc(0, 0, 0, 1);
      check("h2 idle", 32'(bus.state_o), 32'(0));
      cyc(1, 0, 0, 1);
      bus.start_i = 1'b0;
      wait_strobe(30, k);
      check("h2 entry to strobe", 32'(k), 32'(10));
      @(negedge clk);
      check("h2 strobe width", 32'(bus.count_en_o), 32'(0));
      wait_strobe(30, k);
      check("h2 strobe period", 32'(k + 1), 32'(10));

      // Asynchronous reset while a strobe is on the outputs.
      wait_strobe(30, k);
      check("h3 strobe seen", 32'(k <= 30), 32'(1));
      #1 rst = 1'b1;
      #1;
      check("h3 async count_en", 32'(bus.count_en_o), 32'(0));
      check("h3 async running",  32'(bus.running_o),  32'(0));
      check("h3 async state",    32'(bus.state_o),    32'(0));
      check("h3 async clear",    32'(bus.clear_o),    32'(0));

      // Start held across reset release must not start the watch.
      bus.start_i = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      clr = 0;
      repeat (5) begin
         @(negedge clk);
         if (bus.clear_o === 1'b1) clr++;
      end
      check("h4 held state",   32'(bus.state_o),   32'(0));
      check("h4 held running", 32'(bus.running_o), 32'(0));
      check("h4 no clear",     32'(clr),           32'(0));
      cyc(0, 0, 0, 2);
      cyc(1, 0, 0, 1);
      check("h4 fresh press runs", 32'(bus.running_o), 32'(1));
      bus.start_i = 1'b0;
      @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
